riscv_ex_stage: RTL and testbench
=================================

// Module: riscv_ex_stage
// PURPOSE
//  Execute stage of the 5-stage RV32I pipeline: operand forwarding muxes (aluSource), ALU with branch
//  compare (alu), load-use hazard detector (HDU) and the EX/MEM result register. Sits between the
//  ID/EX register and data memory; forwarding select codes come from the external forwarding unit.
// PARAMETERS
//  XLEN    32  datapath width
//  RADDR_W 5   register-index width
// PORTS
//  clock          in  1      single clock, EX/MEM register captures on rising edge
//  clear          in  1      asynchronous, active-low reset of the EX/MEM register
//  ex_data_a      in  XLEN   rs1 value from ID/EX
//  ex_data_b      in  XLEN   rs2 value from ID/EX
//  ex_imm         in  XLEN   sign-extended immediate (byte offset)
//  ex_pc          in  XLEN   instruction word address of EX instruction
//  ex_func        in  4      {instr[30], funct3}
//  ex_alu_op      in  3      ALU operation class (control signals[10:8])
//  ex_alu_src     in  1      1: ALU B = ex_imm, 0: forwarded rs2
//  ex_mem_read    in  1      EX instruction is a load
//  ex_rd          in  RADDR_W destination register of EX instruction
//  id_rs1, id_rs2 in  RADDR_W source registers of ID instruction
//  wb_data        in  XLEN   write-back value (dataD)
//  mem_fwd_data   in  XLEN   current EX/MEM ALU result (fed back for forwarding)
//  forward_a/b    in  2      forwarding selects
//  not_stall      out 1      0 = load-use hazard, freeze PC/IF-ID and bubble ID/EX
//  alu_result     out XLEN   combinational ALU result
//  mem_alu_result out XLEN   registered ALU result
//  mem_branch_cond out 1     registered branch condition
//  mem_branch_addr out XLEN  registered branch target
//  mem_store_data out XLEN   registered forwarded rs2 (store data)
// BEHAVIOUR
//  Forwarding: sel 00 -> ID/EX value, 10 -> mem_fwd_data, 01 -> wb_data, 11 treated as 00; applied
//   independently to A and B. aluB = ex_alu_src ? ex_imm : fwdB. Store data is always fwdB.
//  alu_op 000: ADD (load/store address). 001: branch compare, result = A-B, branch_cond by funct3:
//   000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu, 010/011 -> 0.
//  alu_op 010 (R-type) by funct3: 000 add/sub(func[3]=1), 001 sll, 010 slt, 011 sltu, 100 xor,
//   101 srl/sra(func[3]=1), 110 or, 111 and. alu_op 011 (I-type): same but 000 always add and
//   func[3] honoured only for funct3 101. Other alu_op codes -> ADD.
//  Shift amount = aluB[4:0]; slt/blt/bge signed, sltu/bltu/bgeu unsigned; results wrap mod 2^32.
//  branch_cond is 0 for every alu_op except 001.
//  Branch target = ex_pc + (ex_imm >>> 2) (arithmetic shift, word-addressed PC).
//  not_stall = !(ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2)); purely combinational.
//  EX/MEM register: always enabled, 1-cycle latency; clear low -> all mem_* outputs 0 immediately,
//   independent of clock; release takes effect at the next rising edge.
//  Combinational outputs (alu_result, not_stall) are not affected by clear.
// STRUCTURE
//  Shared package riscv_pkg: ALU_OP_* (ADD/BRANCH/RTYPE/ITYPE), FUNCT3_* constants, FWD_* select codes.
//  One sub-module natural: riscv_alu (pure combinational ALU + branch compare); muxes, hazard
//  logic and EX/MEM register stay in the top.
// TESTING
//  R add: A=8,B=49,alu_op=010,func=0000 -> alu_result 57; next edge mem_alu_result 57.
//  Forward: fwdA=10, mem_fwd_data=5, ex_data_a=0, imm=1, alu_src=1, alu_op=011 -> result 6;
//   fwdA=01, wb_data=7 -> 8.
//  Branch bge: alu_op=001, funct3=101, A=3,B=5 -> cond 0; A=5,B=5 -> 1; A=-1,B=1 bgeu -> 1;
//   ex_pc=4, imm=-8 -> mem_branch_addr 2.
//  Load-use: ex_mem_read=1, ex_rd=2, id_rs2=2 -> not_stall 0; ex_rd=0 or mem_read=0 -> 1.
//  Shifts/sub: sra 0x80000000 by 4 -> 0xF8000000; sub 3-5 -> 0xFFFFFFFE; slt -1<1 -> 1, sltu -> 0.
//  Reset: drive clear low mid-run between edges -> all mem_* 0 immediately; hold through edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I execute stage.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned RADDR_W  = 5;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned FUNC_W   = 4;
    localparam int unsigned FWD_W    = 2;
    localparam int unsigned SHAMT_W  = 5;

    // ALU operation classes from the decoder
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD    = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BRANCH = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE  = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ITYPE  = 3'b011;

    // funct3 for arithmetic/logic operations
    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    // funct3 for conditional branches
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    // Forwarding select codes (11 behaves as ID/EX)
    localparam logic [FWD_W-1:0] FWD_IDEX = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB   = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM  = 2'b10;

    // EX/MEM pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic            branch_cond;
        logic [XLEN-1:0] branch_addr;
        logic [XLEN-1:0] store_data;
    } ex_mem_t;

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32I ALU with branch compare.
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [FUNC_W-1:0]   func,
    output logic [XLEN-1:0]     result,
    output logic                branch_cond
);

    logic [2:0]         funct3;
    logic               alt;
    logic [SHAMT_W-1:0] shamt;

    assign funct3 = func[2:0];
    assign alt    = func[3];
    assign shamt  = b[SHAMT_W-1:0];

    // Operation select; ADD and no branch unless the class says otherwise
    always_comb begin
        result      = a + b;
        branch_cond = 1'b0;
        case (alu_op)
            ALU_OP_BRANCH: begin
                result = a - b;
                case (funct3)
                    FUNCT3_BEQ:  branch_cond = (a == b);
                    FUNCT3_BNE:  branch_cond = (a != b);
                    FUNCT3_BLT:  branch_cond = ($signed(a) < $signed(b));
                    FUNCT3_BGE:  branch_cond = ($signed(a) >= $signed(b));
                    FUNCT3_BLTU: branch_cond = (a < b);
                    FUNCT3_BGEU: branch_cond = (a >= b);
                    default:     branch_cond = 1'b0;
                endcase
            end
            ALU_OP_RTYPE, ALU_OP_ITYPE: begin
                case (funct3)
                    // I-type has no subtract: instr[30] is part of the immediate
                    FUNCT3_ADD:  result = (alt && (alu_op == ALU_OP_RTYPE)) ? (a - b) : (a + b);
                    FUNCT3_SLL:  result = a << shamt;
                    FUNCT3_SLT:  result = XLEN'($signed(a) < $signed(b));
                    FUNCT3_SLTU: result = XLEN'(a < b);
                    FUNCT3_XOR:  result = a ^ b;
                    FUNCT3_SR:   result = alt ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
                    FUNCT3_OR:   result = a | b;
                    FUNCT3_AND:  result = a & b;
                    default:     result = a + b;
                endcase
            end
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/riscv_ex_stage.sv
// Execute stage: forwarding muxes, ALU, load-use hazard detect and EX/MEM register.
module riscv_ex_stage
    import riscv_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic [XLEN-1:0]     ex_data_a,
    input  logic [XLEN-1:0]     ex_data_b,
    input  logic [XLEN-1:0]     ex_imm,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic [FUNC_W-1:0]   ex_func,
    input  logic [ALU_OP_W-1:0] ex_alu_op,
    input  logic                ex_alu_src,
    input  logic                ex_mem_read,
    input  logic [RADDR_W-1:0]  ex_rd,
    input  logic [RADDR_W-1:0]  id_rs1,
    input  logic [RADDR_W-1:0]  id_rs2,
    input  logic [XLEN-1:0]     wb_data,
    input  logic [XLEN-1:0]     mem_fwd_data,
    input  logic [FWD_W-1:0]    forward_a,
    input  logic [FWD_W-1:0]    forward_b,
    output logic                not_stall,
    output logic [XLEN-1:0]     alu_result,
    output logic [XLEN-1:0]     mem_alu_result,
    output logic                mem_branch_cond,
    output logic [XLEN-1:0]     mem_branch_addr,
    output logic [XLEN-1:0]     mem_store_data
);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic            branch_cond;
    logic [XLEN-1:0] branch_addr;
    ex_mem_t         ex_mem_d;
    ex_mem_t         ex_mem_q;

    // Operand A forwarding
    always_comb begin
        fwd_a = ex_data_a;
        case (forward_a)
            FWD_MEM: fwd_a = mem_fwd_data;
            FWD_WB:  fwd_a = wb_data;
            default: fwd_a = ex_data_a;
        endcase
    end

    // Operand B forwarding
    always_comb begin
        fwd_b = ex_data_b;
        case (forward_b)
            FWD_MEM: fwd_b = mem_fwd_data;
            FWD_WB:  fwd_b = wb_data;
            default: fwd_b = ex_data_b;
        endcase
    end

    assign alu_b = ex_alu_src ? ex_imm : fwd_b;

    riscv_alu u_alu (
        .a           (fwd_a),
        .b           (alu_b),
        .alu_op      (ex_alu_op),
        .func        (ex_func),
        .result      (alu_result),
        .branch_cond (branch_cond)
    );

    // PC holds word addresses while the immediate is a byte offset
    assign branch_addr = ex_pc + XLEN'($signed(ex_imm) >>> 2);

    // Load-use hazard: consumer in ID needs a load result not yet available
    assign not_stall = !(ex_mem_read && (ex_rd != '0) &&
                         ((ex_rd == id_rs1) || (ex_rd == id_rs2)));

    assign ex_mem_d.alu_result  = alu_result;
    assign ex_mem_d.branch_cond = branch_cond;
    assign ex_mem_d.branch_addr = branch_addr;
    assign ex_mem_d.store_data  = fwd_b;

    // EX/MEM register, always enabled
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign mem_alu_result  = ex_mem_q.alu_result;
    assign mem_branch_cond = ex_mem_q.branch_cond;
    assign mem_branch_addr = ex_mem_q.branch_addr;
    assign mem_store_data  = ex_mem_q.store_data;

endmodule

// File: tb/tb_riscv_ex_stage.sv
// Scoreboard bench for riscv_ex_stage with a behavioural reference model.
module tb_riscv_ex_stage;

    logic        clock;
    logic        clear;
    logic [31:0] ex_data_a, ex_data_b, ex_imm, ex_pc;
    logic [3:0]  ex_func;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic [31:0] wb_data, mem_fwd_data;
    logic [1:0]  forward_a, forward_b;
    logic        not_stall;
    logic [31:0] alu_result, mem_alu_result, mem_branch_addr, mem_store_data;
    logic        mem_branch_cond;

    riscv_ex_stage dut (
        .clock           (clock),
        .clear           (clear),
        .ex_data_a       (ex_data_a),
        .ex_data_b       (ex_data_b),
        .ex_imm          (ex_imm),
        .ex_pc           (ex_pc),
        .ex_func         (ex_func),
        .ex_alu_op       (ex_alu_op),
        .ex_alu_src      (ex_alu_src),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .wb_data         (wb_data),
        .mem_fwd_data    (mem_fwd_data),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .not_stall       (not_stall),
        .alu_result      (alu_result),
        .mem_alu_result  (mem_alu_result),
        .mem_branch_cond (mem_branch_cond),
        .mem_branch_addr (mem_branch_addr),
        .mem_store_data  (mem_store_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] a, b, imm, pc;
        logic [3:0]  func;
        logic [2:0]  op;
        logic        src, mr;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] wb, mf;
        logic [1:0]  fa, fb;
    } stim_t;

    typedef struct {
        logic [31:0] alu;
        logic        ns;
        logic        cond;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_alu;
    logic        last_ns;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Forwarding choice: 10 = EX/MEM result, 01 = write-back, anything else = ID/EX
    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] idex,
                                         input logic [31:0] mf, input logic [31:0] wb);
        if (sel == 2'b10) return mf;
        if (sel == 2'b01) return wb;
        return idex;
    endfunction

    // Reference ALU from the instruction-set semantics
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op, input logic [3:0] func,
                                    output logic [31:0] r, output logic c);
        int          sa, sbv;
        int unsigned sh;
        logic [2:0]  f3;
        logic [31:0] fill;
        sa = a;
        sbv = b;
        sh = 32'(b[4:0]);
        f3 = func[2:0];
        r = a + b;
        c = 1'b0;
        if (op == 3'd1) begin
            r = a - b;
            if (f3 == 3'd0) c = (a == b);
            else if (f3 == 3'd1) c = (a != b);
            else if (f3 == 3'd4) c = (sa < sbv);
            else if (f3 == 3'd5) c = !(sa < sbv);
            else if (f3 == 3'd6) c = (a < b);
            else if (f3 == 3'd7) c = !(a < b);
        end else if (op == 3'd2 || op == 3'd3) begin
            if (f3 == 3'd0) r = (op == 3'd2 && func[3]) ? a + ~b + 32'd1 : a + b;
            else if (f3 == 3'd1) r = a << sh;
            else if (f3 == 3'd2) r = (sa < sbv) ? 32'd1 : 32'd0;
            else if (f3 == 3'd3) r = (a < b) ? 32'd1 : 32'd0;
            else if (f3 == 3'd4) r = a ^ b;
            else if (f3 == 3'd5) begin
                fill = (func[3] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                r = (a >> sh) | fill;
            end
            else if (f3 == 3'd6) r = a | b;
            else r = a & b;
        end
    endfunction

    // Apply one instruction at the falling edge and queue its expected response
    task automatic drive(input stim_t s);
        exp_t        e;
        logic [31:0] fa, fb, bval;
        int          imm_s;
        @(negedge clock);
        ex_data_a = s.a; ex_data_b = s.b; ex_imm = s.imm; ex_pc = s.pc;
        ex_func = s.func; ex_alu_op = s.op; ex_alu_src = s.src; ex_mem_read = s.mr;
        ex_rd = s.rd; id_rs1 = s.rs1; id_rs2 = s.rs2;
        wb_data = s.wb; mem_fwd_data = s.mf; forward_a = s.fa; forward_b = s.fb;
        fa = pick(s.fa, s.a, s.mf, s.wb);
        fb = pick(s.fb, s.b, s.mf, s.wb);
        bval = s.src ? s.imm : fb;
        ref_alu(fa, bval, s.op, s.func, e.alu, e.cond);
        imm_s = s.imm;
        e.addr  = s.pc + 32'(imm_s >>> 2);
        e.store = fb;
        e.ns    = !(s.mr && s.rd != 5'd0 && (s.rd == s.rs1 || s.rd == s.rs2));
        last_alu = e.alu;
        last_ns  = e.ns;
        sbq.push_back(e);
    endtask

    // Monitor: every rising edge with a pending instruction, check comb and registered outputs
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("alu_result", alu_result, e.alu);
                check("not_stall", 32'(not_stall), 32'(e.ns));
                check("mem_alu_result", mem_alu_result, e.alu);
                check("mem_branch_cond", 32'(mem_branch_cond), 32'(e.cond));
                check("mem_branch_addr", mem_branch_addr, e.addr);
                check("mem_store_data", mem_store_data, e.store);
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_mem_alu_result"}, mem_alu_result, 32'd0);
        check({tag, "_mem_branch_cond"}, 32'(mem_branch_cond), 32'd0);
        check({tag, "_mem_branch_addr"}, mem_branch_addr, 32'd0);
        check({tag, "_mem_store_data"}, mem_store_data, 32'd0);
    endtask

    function automatic logic [31:0] rnd_data();
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 7));
        return $urandom;
    endfunction

    initial begin
        stim_t s;
        int    wait_cycles;
        clear = 1'b0;
        s = '0;
        {ex_data_a, ex_data_b, ex_imm, ex_pc, ex_func, ex_alu_op, ex_alu_src, ex_mem_read,
         ex_rd, id_rs1, id_rs2, wb_data, mem_fwd_data, forward_a, forward_b} = s;
        #2;
        check_cleared("reset");
        check("reset_not_stall", 32'(not_stall), 32'd1);
        @(negedge clock);
        clear = 1'b1;

        // R-type add 8+49
        s = '0; s.a = 32'd8; s.b = 32'd49; s.op = 3'b010; s.func = 4'b0000; drive(s);
        // Forward from EX/MEM: 5 + imm 1
        s = '0; s.fa = 2'b10; s.mf = 32'd5; s.imm = 32'd1; s.src = 1'b1; s.op = 3'b011; drive(s);
        // Forward from WB: 7 + 1
        s.fa = 2'b01; s.wb = 32'd7; drive(s);
        // Select 11 behaves as ID/EX
        s = '0; s.fa = 2'b11; s.fb = 2'b11; s.a = 32'd20; s.b = 32'd22; s.mf = 32'd99;
        s.wb = 32'd77; s.op = 3'b010; drive(s);
        // Branches: bge 3>=5, bge 5>=5, bgeu -1>=1, target 4 + (-8>>>2)
        s = '0; s.op = 3'b001; s.func = 4'b0101; s.a = 32'd3; s.b = 32'd5; drive(s);
        s.a = 32'd5; drive(s);
        s.func = 4'b0111; s.a = 32'hFFFF_FFFF; s.b = 32'd1; s.pc = 32'd4; s.imm = 32'hFFFF_FFF8; drive(s);
        s.func = 4'b0010; drive(s);
        // Load-use hazard and its exemptions
        s = '0; s.mr = 1'b1; s.rd = 5'd2; s.rs2 = 5'd2; s.rs1 = 5'd7; drive(s);
        s.rd = 5'd0; s.rs2 = 5'd0; drive(s);
        s.rd = 5'd2; s.rs2 = 5'd2; s.mr = 1'b0; drive(s);
        // sra, sub, slt, sltu, I-type ignores func[3] on add
        s = '0; s.op = 3'b010; s.func = 4'b1101; s.a = 32'h8000_0000; s.b = 32'd4; drive(s);
        s.func = 4'b1000; s.a = 32'd3; s.b = 32'd5; drive(s);
        s.func = 4'b0010; s.a = 32'hFFFF_FFFF; s.b = 32'd1; drive(s);
        s.func = 4'b0011; drive(s);
        s.op = 3'b011; s.func = 4'b1000; s.a = 32'd3; s.b = 32'd5; drive(s);

        // Asynchronous clear mid-cycle, held across a rising edge
        @(posedge clock);
        #3;
        clear = 1'b0;
        #1;
        check_cleared("async_clear");
        check("clear_alu_result", alu_result, last_alu);
        check("clear_not_stall", 32'(not_stall), 32'(last_ns));
        @(posedge clock);
        #2;
        check_cleared("clear_hold");
        @(negedge clock);
        clear = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.a = rnd_data(); s.b = rnd_data(); s.imm = rnd_data(); s.pc = $urandom;
            s.wb = rnd_data(); s.mf = rnd_data();
            s.func = 4'($urandom_range(0, 15)); s.op = 3'($urandom_range(0, 7));
            s.src = 1'($urandom_range(0, 1)); s.mr = 1'($urandom_range(0, 1));
            s.rd = 5'($urandom_range(0, 3)); s.rs1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3));
            s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
            drive(s);
        end

        wait_cycles = 0;
        while (sbq.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
